map_port_arbiter: RTL and testbench
===================================

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of cell-update requesters (0 = pacman, 1 = ghost1, 2 = ghost2).
REQ-002 SHALL have parameter RD_LAT, default 2, map RAM port-B read latency in cycles from address to q.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 req  in  N_REQ  per-requester level request; held until its done pulse.
REQ-007 req_x  in  6*N_REQ  target column per requester (slice i = [6i+5:6i]).
REQ-008 req_y  in  5*N_REQ  target row per requester.
REQ-009 req_code  in  4*N_REQ  new 4-bit object code per requester.
REQ-010 done  out  N_REQ  one-cycle pulse to the granted requester at end of transaction.
REQ-011 err  out  1  valid with done; 1 = out-of-range cell, no write performed.
REQ-012 old_code  out  4  code previously stored in the cell; valid with done when err = 0.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 ram_addr  out  5  map RAM port-B row address.
REQ-015 ram_wren  out  1  map RAM port-B write enable.
REQ-016 ram_wrdata  out  160  full row written back.
REQ-017 ram_redata  in  160  map RAM port-B read data.

Function
REQ-018 SHALL implement FSM IDLE -> READ -> WRITE -> DONE -> IDLE.
REQ-019 In IDLE with any req bit high, SHALL grant one requester round-robin: search starts at last_grant+1 mod N_REQ.
REQ-020 On grant, SHALL latch x, y, code and index; later changes on the request inputs SHALL NOT affect the transaction.
REQ-021 If latched x > 39 or y > 29, SHALL skip READ/WRITE and go to DONE with err = 1, ram_wren = 0.
REQ-022 READ SHALL last RD_LAT+1 cycles with ram_addr = latched y; ram_redata SHALL be captured in the last READ cycle.
REQ-023 WRITE SHALL last exactly 1 cycle: ram_wren = 1, ram_addr = y, ram_wrdata = captured row with bits [159-4x : 156-4x] replaced by code, all other bits unchanged.
REQ-024 old_code SHALL equal captured row bits [159-4x : 156-4x].
REQ-025 DONE SHALL last 1 cycle: done[index] = 1, other done bits = 0; last_grant updated to index.
REQ-026 For a valid cell, SHALL assert done exactly RD_LAT+3 cycles after the grant cycle (cycle 5 for RD_LAT = 2). An out-of-range cell SHALL assert done 1 cycle after grant.
REQ-027 A req bit still high in the cycle after DONE SHALL be treated as a new request; requesters drop req on done.
REQ-028 A req that falls mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-029 SHALL hold at most one transaction in flight; there is no request queue beyond the level req inputs.
REQ-030 ram_wren SHALL be 0 in every state except WRITE.

Reset
REQ-031 On reset assertion, with any state active, SHALL go to IDLE immediately: ram_wren = 0, done = 0, err = 0, busy = 0, old_code = 0, ram_addr = 0, last_grant = N_REQ-1 (first grant favours requester 0). Any in-flight transaction SHALL be discarded without a write.

Structure
REQ-032 A shared package map_pkg SHALL hold MAP_COLS = 40, MAP_ROWS = 30, CELL_W = 4, ROW_W = 160, the cell-code constants and the arbiter state enum.
REQ-033 The round-robin pick SHALL be a sub-module rr_picker: inputs req and last_grant, outputs grant_valid and grant_idx.

Verification
REQ-034 Cell update: row 5 preloaded all 0x0 except cell x=3 = 0x2; req[0] with x=3, y=5, code=0x4 -> ram_wren one cycle, bits [147:144] = 0x4, rest of row unchanged; done[0] in cycle 5 after grant with old_code = 0x2, err = 0.
REQ-035 Contention: req = 3'b111 held, each dropped on its done -> grants in order 0, 1, 2; then req = 3'b101 again -> next grant is 0 (pointer at 2).
REQ-036 Range check: req[1] with x=40, y=0 -> done[1] one cycle after grant with err = 1 and no ram_wren pulse; req[2] with y=31 -> same behaviour.
REQ-037 Reset mid-op: assert reset during the second READ cycle -> ram_wren never pulses, busy = 0 immediately; after release, req[1] alone is granted first and completes normally.
REQ-038 Boundary nibbles: x=0 writes bits [159:156]; x=39 writes bits [3:0]; same-row back-to-back updates by requesters 0 then 1 both persist in the final row.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map geometry, cell codes and arbiter state encoding for the map RAM
// update path.
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int CELL_W   = 4;
    localparam int ROW_W    = MAP_COLS * CELL_W;
    localparam int X_W      = 6;
    localparam int Y_W      = 5;

    localparam logic [CELL_W-1:0] CODE_EMPTY  = 4'h0;
    localparam logic [CELL_W-1:0] CODE_WALL   = 4'h1;
    localparam logic [CELL_W-1:0] CODE_DOT    = 4'h2;
    localparam logic [CELL_W-1:0] CODE_POWER  = 4'h3;
    localparam logic [CELL_W-1:0] CODE_PACMAN = 4'h4;
    localparam logic [CELL_W-1:0] CODE_GHOST  = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/map_port_arbiter_rr_picker.sv
// Round-robin requester pick: the first asserted request found after
// last_grant (wrapping) wins.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int cand;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = int'(last_grant) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Arbitrates cell-update requests onto map RAM port B with a
// read-modify-write of the full 160-bit row holding the target cell.
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int RD_LAT = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   req_x,
    input  logic [5*N_REQ-1:0]   req_y,
    input  logic [4*N_REQ-1:0]   req_code,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [CELL_W-1:0]    old_code,
    output logic                 busy,
    output logic [Y_W-1:0]       ram_addr,
    output logic                 ram_wren,
    output logic [ROW_W-1:0]     ram_wrdata,
    input  logic [ROW_W-1:0]     ram_redata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 1) + 1;

    arb_state_t          state_reg;
    logic [IDX_W-1:0]    last_grant_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [X_W-1:0]      x_reg;
    logic [CELL_W-1:0]   code_reg;
    logic [CELL_W-1:0]   old_nib_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic                grant_valid;
    logic [IDX_W-1:0]    grant_idx;
    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [CELL_W-1:0]   sel_code;
    logic                sel_out_of_range;
    logic [ROW_W-1:0]    merged_row;
    logic [CELL_W-1:0]   old_nib;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req         (req),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_x    = req_x[X_W*int'(grant_idx) +: X_W];
    assign sel_y    = req_y[Y_W*int'(grant_idx) +: Y_W];
    assign sel_code = req_code[CELL_W*int'(grant_idx) +: CELL_W];
    assign sel_out_of_range = (sel_x > X_W'(MAP_COLS - 1)) || (sel_y > Y_W'(MAP_ROWS - 1));

    // Cell 0 sits in the most significant nibble of the row.
    generate
        for (genvar gi = 0; gi < MAP_COLS; gi++) begin : g_cell
            localparam int HI = ROW_W - 1 - CELL_W * gi;
            assign merged_row[HI -: CELL_W] =
                (x_reg == X_W'(gi)) ? code_reg : ram_redata[HI -: CELL_W];
        end
    endgenerate

    assign old_nib = ram_redata[ROW_W - 1 - CELL_W*int'(x_reg) -: CELL_W];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= IDX_W'(N_REQ - 1);
            idx_reg        <= '0;
            x_reg          <= '0;
            code_reg       <= '0;
            old_nib_reg    <= '0;
            cnt_reg        <= '0;
            done           <= '0;
            err            <= 1'b0;
            old_code       <= '0;
            busy           <= 1'b0;
            ram_addr       <= '0;
            ram_wren       <= 1'b0;
            ram_wrdata     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        idx_reg  <= grant_idx;
                        x_reg    <= sel_x;
                        code_reg <= sel_code;
                        busy     <= 1'b1;
                        if (sel_out_of_range) begin
                            done      <= N_REQ'(1) << grant_idx;
                            err       <= 1'b1;
                            old_code  <= '0;
                            state_reg <= ST_DONE;
                        end else begin
                            ram_addr  <= sel_y;
                            cnt_reg   <= '0;
                            state_reg <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // Address was presented on entry, so q is valid after RD_LAT more cycles.
                    if (cnt_reg == CNT_W'(RD_LAT)) begin
                        ram_wrdata  <= merged_row;
                        old_nib_reg <= old_nib;
                        ram_wren    <= 1'b1;
                        state_reg   <= ST_WRITE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WRITE: begin
                    ram_wren  <= 1'b0;
                    done      <= N_REQ'(1) << idx_reg;
                    err       <= 1'b0;
                    old_code  <= old_nib_reg;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    done           <= '0;
                    err            <= 1'b0;
                    busy           <= 1'b0;
                    last_grant_reg <= idx_reg;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Randomized scoreboard bench for map_port_arbiter with a behavioural map RAM
// and a cell-level reference model of the map contents and round-robin order.
module tb_map_port_arbiter;
    import map_pkg::*;

    localparam int N      = 3;
    localparam int RD_LAT = 2;
    localparam int TMO    = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [6*N-1:0] req_x;
    logic [5*N-1:0] req_y;
    logic [4*N-1:0] req_code;
    logic [N-1:0]  done;
    logic          err;
    logic [3:0]    old_code;
    logic          busy;
    logic [4:0]    ram_addr;
    logic          ram_wren;
    logic [159:0]  ram_wrdata;
    logic [159:0]  ram_redata;

    always #5 clk = ~clk;

    map_port_arbiter #(.N_REQ(N), .RD_LAT(RD_LAT)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_code   (req_code),
        .done       (done),
        .err        (err),
        .old_code   (old_code),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .ram_wrdata (ram_wrdata),
        .ram_redata (ram_redata)
    );

    // Reference map contents, one nibble per cell.
    logic [3:0] model_nib [32][40];
    int ptr;
    int expected_wren;

    function automatic logic [159:0] row_of(input int r);
        logic [159:0] row;
        row = '0;
        for (int c = 0; c < 40; c++) row[159-4*c -: 4] = model_nib[r][c];
        return row;
    endfunction

    // Behavioural map RAM with RD_LAT-cycle read latency.
    logic [159:0] ram [32];
    logic [159:0] rd_pipe [RD_LAT];
    logic preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int r = 0; r < 32; r++) ram[r] <= row_of(r);
        end else if (ram_wren) begin
            ram[ram_addr] <= ram_wrdata;
        end
        rd_pipe[0] <= ram[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_redata = rd_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    typedef struct {
        int       idx;
        bit       err;
        logic [3:0] old;
        int       lat;
        int       wrens;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: pops one expectation per done pulse.
    int   cyc = 0;
    int   rise_cyc = 0;
    int   wren_cnt = 0;
    int   total_wren = 0;
    logic busy_d = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            busy_d = 1'b0;
        end else begin
            if (busy && !busy_d) begin
                rise_cyc = cyc;
                wren_cnt = 0;
            end
            if (ram_wren) begin
                wren_cnt++;
                total_wren++;
            end
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got %b expected none", done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_onehot", longint'(done), longint'(1) << e.idx);
                    check("err", longint'(err), longint'(e.err));
                    if (!e.err) check("old_code", longint'(old_code), longint'(e.old));
                    check("latency", cyc - rise_cyc, e.lat);
                    check("wren_pulses", wren_cnt, e.wrens);
                end
            end
            busy_d = busy;
        end
    end

    int b_x[N];
    int b_y[N];
    int b_code[N];

    task automatic run_batch(input logic [N-1:0] mask);
        int order[$];
        int k_done;
        int t;
        int cur;
        int bad;
        exp_t e;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (mask[i]) order.push_back(i);
        end
        foreach (order[j]) begin
            int i;
            i = order[j];
            e.idx = i;
            e.err = (b_x[i] > 39) || (b_y[i] > 29);
            if (!e.err) begin
                e.old   = model_nib[b_y[i]][b_x[i]];
                model_nib[b_y[i]][b_x[i]] = 4'(b_code[i]);
                e.lat   = RD_LAT + 2;
                e.wrens = 1;
                expected_wren++;
            end else begin
                e.old   = 4'h0;
                e.lat   = 0;
                e.wrens = 0;
            end
            exp_q.push_back(e);
            ptr = i;
        end
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_x[i*6 +: 6]    = 6'(b_x[i]);
                req_y[i*5 +: 5]    = 5'(b_y[i]);
                req_code[i*4 +: 4] = 4'(b_code[i]);
            end
        end
        req    = mask;
        k_done = 0;
        t      = 0;
        while (k_done < order.size() && t < TMO) begin
            @(negedge clk);
            t++;
            if (done != '0) begin
                req    = req & ~done;
                k_done++;
            end else if (busy && k_done < order.size()) begin
                // Disturb the in-flight requester's inputs; the latched copy must win.
                cur = order[k_done];
                req_x[cur*6 +: 6]    = 6'($urandom);
                req_y[cur*5 +: 5]    = 5'($urandom);
                req_code[cur*4 +: 4] = 4'($urandom);
                if ($urandom_range(0, 7) == 0) req[cur] = 1'b0;
            end
        end
        if (t >= TMO) begin
            checks++;
            errors++;
            $display("FAIL batch_timeout: got %0d of %0d done", k_done, order.size());
            exp_q.delete();
        end
        req = '0;
        @(negedge clk);
        bad = 0;
        for (int r = 0; r < 30; r++) if (ram[r] != row_of(r)) bad++;
        check("ram_rows_mismatched", bad, 0);
    endtask

    initial begin
        rst      = 1'b1;
        preload  = 1'b1;
        req      = '0;
        req_x    = '0;
        req_y    = '0;
        req_code = '0;
        ptr      = N - 1;
        expected_wren = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 40; c++) model_nib[r][c] = 4'($urandom);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_err", err, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_old_code", old_code, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: 0,1,2 then 0 again with 3'b101.
        for (int i = 0; i < N; i++) begin
            b_x[i] = 10 + i; b_y[i] = 3; b_code[i] = 6 + i;
        end
        run_batch(3'b111);
        run_batch(3'b101);

        // Single cell update on a known row.
        for (int c = 0; c < 40; c++) model_nib[5][c] = 4'h0;
        model_nib[5][3] = 4'h2;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        b_x[0] = 3; b_y[0] = 5; b_code[0] = 4;
        run_batch(3'b001);
        check("row5_nibble_147_144", longint'(ram[5][147:144]), 4);

        // Out-of-range cells.
        b_x[1] = 40; b_y[1] = 0;  b_code[1] = 7;
        run_batch(3'b010);
        b_x[2] = 5;  b_y[2] = 31; b_code[2] = 7;
        run_batch(3'b100);

        // Boundary nibbles in one row from two requesters.
        b_x[0] = 0;  b_y[0] = 7; b_code[0] = 4'hA;
        b_x[1] = 39; b_y[1] = 7; b_code[1] = 4'h5;
        run_batch(3'b011);
        check("x0_nibble", longint'(ram[7][159:156]), 4'hA);
        check("x39_nibble", longint'(ram[7][3:0]), 4'h5);

        // Reset during the second READ cycle.
        req_x[5:0] = 6'd1; req_y[4:0] = 5'd2; req_code[3:0] = 4'hF;
        req = 3'b001;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_wren", ram_wren, 0);
        check("midrst_done", done, 0);
        check("midrst_addr", ram_addr, 0);
        req = '0;
        ptr = N - 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        b_x[1] = 20; b_y[1] = 2; b_code[1] = 9;
        run_batch(3'b010);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                b_x[i]    = $urandom_range(0, 44);
                b_y[i]    = $urandom_range(0, 31);
                b_code[i] = $urandom_range(0, 15);
            end
            run_batch(3'($urandom_range(1, 7)));
        end

        repeat (3) @(negedge clk);
        check("total_wren", total_wren, expected_wren);
        check("queue_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
